// File: rtl/axi_burst_seq.sv
`timescale 1ns/1ps
// AXI slave-side burst sequencer: expands one AR/AW request into len+1 address
// beats on a valid/ready interface, with FIXED/INCR/WRAP address generation.
module axi_burst_seq #(
    parameter int   ADDR_WIDTH = 12,
    parameter int   DATA_WIDTH = 32,
    parameter int   ID_WIDTH   = 4,
    parameter logic ALIGN_ADDR = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ax_valid,
    output logic                  ax_ready,
    input  logic [ADDR_WIDTH-1:0] ax_addr,
    input  logic [7:0]            ax_len,
    input  logic [2:0]            ax_size,
    input  logic [1:0]            ax_burst,
    input  logic [ID_WIDTH-1:0]   ax_id,
    output logic                  beat_valid,
    input  logic                  beat_ready,
    output logic [ADDR_WIDTH-1:0] beat_addr,
    output logic [ID_WIDTH-1:0]   beat_id,
    output logic [7:0]            beat_idx,
    output logic                  beat_last,
    output logic                  beat_err,
    output logic                  busy
);

    localparam int         DATA_SIZE   = $clog2(DATA_WIDTH) - 3;
    localparam logic [2:0] DATA_SIZE_L = 3'(DATA_SIZE);

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] BURST_RSVD  = 2'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [7:0]            idx_q, idx_d;
    logic                  err_q, err_d;

    logic                  beat_fire;
    logic                  ax_accept;
    logic [ADDR_WIDTH-1:0] nbytes, incr_addr, align_mask, wrap_mask, next_addr;
    logic [2:0]            align_size;
    logic [ADDR_WIDTH-1:0] ax_size_mask;
    logic                  wrap_len_ok;

    assign busy       = (state_q == BURST);
    assign beat_valid = busy;
    assign beat_addr  = addr_q;
    assign beat_id    = id_q;
    assign beat_idx   = idx_q;
    assign beat_err   = err_q;
    // Gated by busy so the reset value is 0 even though idx and len both reset to 0.
    assign beat_last  = busy & (idx_q == len_q);
    assign beat_fire  = beat_valid & beat_ready;
    assign ax_ready   = !rst & (!busy | (beat_fire & beat_last));
    assign ax_accept  = ax_valid & ax_ready;

    // Next beat address from the captured burst parameters.
    always_comb begin
        nbytes     = ADDR_WIDTH'(1) << size_q;
        align_size = (size_q > DATA_SIZE_L) ? DATA_SIZE_L : size_q;
        align_mask = (ADDR_WIDTH'(1) << align_size) - ADDR_WIDTH'(1);
        wrap_mask  = ADDR_WIDTH'(len_q[3:0]) << size_q;
        incr_addr  = addr_q + nbytes;
        case (burst_q)
            BURST_INCR: next_addr = ALIGN_ADDR ? (incr_addr & ~align_mask) : incr_addr;
            BURST_WRAP: next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
            default:    next_addr = addr_q;
        endcase
    end

    // Legality of the incoming request; latched once and held for the burst.
    always_comb begin
        ax_size_mask = (ADDR_WIDTH'(1) << ax_size) - ADDR_WIDTH'(1);
        wrap_len_ok  = (ax_len == 8'd1) || (ax_len == 8'd3) ||
                       (ax_len == 8'd7) || (ax_len == 8'd15);
        err_d        = (ax_burst == BURST_RSVD) || (ax_size > DATA_SIZE_L) ||
                       ((ax_burst == BURST_WRAP) && !wrap_len_ok) ||
                       ((ax_burst == BURST_WRAP) && ((ax_addr & ax_size_mask) != '0));
        if (!ax_accept) begin
            err_d = err_q;
        end
    end

    // NOTE: every signal gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        id_d    = id_q;
        idx_d   = idx_q;
        if (ax_accept) begin
            // Also covers the back-to-back case: the new burst replaces the last beat.
            state_d = BURST;
            addr_d  = ax_addr;
            len_d   = ax_len;
            size_d  = ax_size;
            burst_d = ax_burst;
            id_d    = ax_id;
            idx_d   = 8'd0;
        end else if (beat_fire) begin
            if (beat_last) begin
                state_d = IDLE;
            end else begin
                idx_d  = idx_q + 8'd1;
                addr_d = next_addr;
            end
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= BURST_FIXED;
            id_q    <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            id_q    <= id_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_axi_burst_seq.sv
`timescale 1ns/1ps
// Scoreboard bench for axi_burst_seq: two instances (ALIGN_ADDR 1 and 0) share
// stimulus; expected beats are queued at request time and popped on each beat.
module tb_axi_burst_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ax_valid = 1'b0;
    logic [11:0] ax_addr = '0;
    logic [7:0]  ax_len = '0;
    logic [2:0]  ax_size = '0;
    logic [1:0]  ax_burst = '0;
    logic [3:0]  ax_id = '0;
    logic        beat_ready = 1'b1;

    logic        ax_ready, beat_valid, beat_last, beat_err, busy;
    logic [11:0] beat_addr;
    logic [3:0]  beat_id;
    logic [7:0]  beat_idx;

    logic        ax_ready_na, beat_valid_na, beat_last_na, beat_err_na, busy_na;
    logic [11:0] beat_addr_na;
    logic [3:0]  beat_id_na;
    logic [7:0]  beat_idx_na;

    always #5 clk = ~clk;

    axi_burst_seq dut (
        .clk(clk), .rst(rst), .ax_valid(ax_valid), .ax_ready(ax_ready),
        .ax_addr(ax_addr), .ax_len(ax_len), .ax_size(ax_size), .ax_burst(ax_burst),
        .ax_id(ax_id), .beat_valid(beat_valid), .beat_ready(beat_ready),
        .beat_addr(beat_addr), .beat_id(beat_id), .beat_idx(beat_idx),
        .beat_last(beat_last), .beat_err(beat_err), .busy(busy)
    );

    axi_burst_seq #(.ALIGN_ADDR(1'b0)) dut_na (
        .clk(clk), .rst(rst), .ax_valid(ax_valid), .ax_ready(ax_ready_na),
        .ax_addr(ax_addr), .ax_len(ax_len), .ax_size(ax_size), .ax_burst(ax_burst),
        .ax_id(ax_id), .beat_valid(beat_valid_na), .beat_ready(beat_ready),
        .beat_addr(beat_addr_na), .beat_id(beat_id_na), .beat_idx(beat_idx_na),
        .beat_last(beat_last_na), .beat_err(beat_err_na), .busy(busy_na)
    );

    typedef struct {
        logic [11:0] addr;
        logic [11:0] addr_na;
        logic [3:0]  id;
        logic [7:0]  idx;
        logic        last;
        logic        err;
    } beat_t;

    beat_t sb[$];
    int    fire_log[$];
    int    n_checks = 0;
    int    n_err = 0;
    int    cycle = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference next-address model, written bit-by-bit.
    function automatic logic [11:0] model_next(input logic [11:0] a, input logic [7:0] len,
                                               input logic [2:0] sz, input logic [1:0] b,
                                               input bit align);
        logic [11:0] nb, s, m;
        int lim;
        nb = 12'd1 << sz;
        s  = a;
        if (b == 2'd1) begin
            s = a + nb;
            lim = (sz > 3'd2) ? 2 : int'(sz);
            if (align) for (int k = 0; k < lim; k++) s[k] = 1'b0;
        end else if (b == 2'd2) begin
            m = 12'(len[3:0]) << sz;
            s = (a & ~m) | ((a + nb) & m);
        end
        return s;
    endfunction

    function automatic logic model_err(input logic [11:0] a, input logic [7:0] len,
                                       input logic [2:0] sz, input logic [1:0] b);
        logic [11:0] nb;
        nb = 12'd1 << sz;
        return (b == 2'd3) || (sz > 3'd2) ||
               ((b == 2'd2) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) ||
               ((b == 2'd2) && ((a % nb) != 12'd0));
    endfunction

    task automatic exp1(input logic [11:0] a, input logic [11:0] a_na, input logic [3:0] id,
                        input logic [7:0] idx, input logic last, input logic err);
        beat_t e;
        e.addr = a; e.addr_na = a_na; e.id = id; e.idx = idx; e.last = last; e.err = err;
        sb.push_back(e);
    endtask

    task automatic push_model(input logic [11:0] a, input logic [7:0] len, input logic [2:0] sz,
                              input logic [1:0] b, input logic [3:0] id);
        logic [11:0] x, x_na;
        logic e;
        x = a; x_na = a;
        e = model_err(a, len, sz, b);
        for (int i = 0; i <= int'(len); i++) begin
            exp1(x, x_na, id, 8'(i), (i == int'(len)), e);
            x    = model_next(x, len, sz, b, 1'b1);
            x_na = model_next(x_na, len, sz, b, 1'b0);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send(input logic [11:0] a, input logic [7:0] len, input logic [2:0] sz,
                        input logic [1:0] b, input logic [3:0] id);
        int n;
        ax_addr = a; ax_len = len; ax_size = sz; ax_burst = b; ax_id = id;
        ax_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ax_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ax_ready) check("ax_handshake_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        ax_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || sb.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (busy || sb.size() != 0) check("drain_timeout", 32'd0, 32'd1);
        sync();
    endtask

    // Monitor: scoreboard compare on every completed beat, plus stall stability.
    logic        stalled_prev = 1'b0;
    logic [11:0] s_addr;
    logic [3:0]  s_id;
    logic [7:0]  s_idx;
    logic        s_last, s_err;

    always @(negedge clk) begin
        beat_t e;
        cycle++;
        if (!rst && stalled_prev) begin
            check("stall_valid", 32'(beat_valid), 32'd1);
            check("stall_addr", 32'(beat_addr), 32'(s_addr));
            check("stall_id", 32'(beat_id), 32'(s_id));
            check("stall_idx", 32'(beat_idx), 32'(s_idx));
            check("stall_last", 32'(beat_last), 32'(s_last));
            check("stall_err", 32'(beat_err), 32'(s_err));
        end
        stalled_prev = !rst && beat_valid && !beat_ready;
        s_addr = beat_addr; s_id = beat_id; s_idx = beat_idx; s_last = beat_last; s_err = beat_err;
        if (!rst && beat_valid && beat_ready) begin
            fire_log.push_back(cycle);
            if (sb.size() == 0) begin
                check("unexpected_beat", 32'(beat_addr), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("beat_addr", 32'(beat_addr), 32'(e.addr));
                check("beat_addr_noalign", 32'(beat_addr_na), 32'(e.addr_na));
                check("beat_id", 32'(beat_id), 32'(e.id));
                check("beat_idx", 32'(beat_idx), 32'(e.idx));
                check("beat_last", 32'(beat_last), 32'(e.last));
                check("beat_err", 32'(beat_err), 32'(e.err));
            end
        end
    end

    initial begin
        bit done;
        // Reset state.
        @(negedge clk);
        check("rst_ax_ready", 32'(ax_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_beat_valid", 32'(beat_valid), 32'd0);
        check("rst_beat_addr", 32'(beat_addr), 32'd0);
        check("rst_beat_id", 32'(beat_id), 32'd0);
        check("rst_beat_idx", 32'(beat_idx), 32'd0);
        check("rst_beat_last", 32'(beat_last), 32'd0);
        check("rst_beat_err", 32'(beat_err), 32'd0);
        sync();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ax_ready", 32'(ax_ready), 32'd1);
        sync();

        // INCR aligned, with first-beat latency check.
        exp1(12'h100, 12'h100, 4'd1, 8'd0, 1'b0, 1'b0);
        exp1(12'h104, 12'h104, 4'd1, 8'd1, 1'b0, 1'b0);
        exp1(12'h108, 12'h108, 4'd1, 8'd2, 1'b0, 1'b0);
        exp1(12'h10C, 12'h10C, 4'd1, 8'd3, 1'b1, 1'b0);
        send(12'h100, 8'd3, 3'd2, 2'd1, 4'd1);
        @(negedge clk);
        check("first_beat_latency", 32'(beat_valid), 32'd1);
        wait_idle();

        // WRAP legal, then WRAP with illegal len.
        exp1(12'h108, 12'h108, 4'd2, 8'd0, 1'b0, 1'b0);
        exp1(12'h10C, 12'h10C, 4'd2, 8'd1, 1'b0, 1'b0);
        exp1(12'h100, 12'h100, 4'd2, 8'd2, 1'b0, 1'b0);
        exp1(12'h104, 12'h104, 4'd2, 8'd3, 1'b1, 1'b0);
        send(12'h108, 8'd3, 3'd2, 2'd2, 4'd2);
        wait_idle();
        exp1(12'h108, 12'h108, 4'd3, 8'd0, 1'b0, 1'b1);
        exp1(12'h108, 12'h108, 4'd3, 8'd1, 1'b0, 1'b1);
        exp1(12'h108, 12'h108, 4'd3, 8'd2, 1'b1, 1'b1);
        send(12'h108, 8'd2, 3'd2, 2'd2, 4'd3);
        wait_idle();

        // INCR unaligned: realigned vs. not realigned.
        exp1(12'h101, 12'h101, 4'd4, 8'd0, 1'b0, 1'b0);
        exp1(12'h104, 12'h105, 4'd4, 8'd1, 1'b0, 1'b0);
        exp1(12'h108, 12'h109, 4'd4, 8'd2, 1'b1, 1'b0);
        send(12'h101, 8'd2, 3'd2, 2'd1, 4'd4);
        wait_idle();

        // FIXED, INCR wrapping past the top of the address space, single beat.
        for (int i = 0; i < 3; i++) exp1(12'h040, 12'h040, 4'd5, 8'(i), (i == 2), 1'b0);
        send(12'h040, 8'd2, 3'd2, 2'd0, 4'd5);
        wait_idle();
        exp1(12'hFFC, 12'hFFC, 4'd6, 8'd0, 1'b0, 1'b0);
        exp1(12'h000, 12'h000, 4'd6, 8'd1, 1'b1, 1'b0);
        send(12'hFFC, 8'd1, 3'd2, 2'd1, 4'd6);
        wait_idle();
        exp1(12'h200, 12'h200, 4'd7, 8'd0, 1'b1, 1'b0);
        send(12'h200, 8'd0, 3'd2, 2'd1, 4'd7);
        wait_idle();

        // Back-to-back: four beats on four consecutive cycles.
        exp1(12'h300, 12'h300, 4'd8, 8'd0, 1'b0, 1'b0);
        exp1(12'h304, 12'h304, 4'd8, 8'd1, 1'b1, 1'b0);
        exp1(12'h310, 12'h310, 4'd9, 8'd0, 1'b0, 1'b0);
        exp1(12'h314, 12'h314, 4'd9, 8'd1, 1'b1, 1'b0);
        fire_log.delete();
        send(12'h300, 8'd1, 3'd2, 2'd1, 4'd8);
        send(12'h310, 8'd1, 3'd2, 2'd1, 4'd9);
        wait_idle();
        check("b2b_beats", 32'(fire_log.size()), 32'd4);
        if (fire_log.size() == 4) check("b2b_no_bubble", 32'(fire_log[3] - fire_log[0]), 32'd3);

        // Random requests under a random beat_ready stall pattern.
        done = 1'b0;
        fork
            begin
                for (int r = 0; r < 12; r++) begin
                    logic [11:0] a;
                    logic [7:0]  l;
                    logic [2:0]  sz;
                    logic [1:0]  b;
                    a  = 12'($urandom);
                    l  = 8'($urandom_range(0, 7));
                    sz = 3'($urandom_range(0, 3));
                    b  = 2'($urandom_range(0, 3));
                    if (b == 2'd2 && $urandom_range(0, 1) == 1) begin
                        l = (r % 2 == 0) ? 8'd3 : 8'd7;
                        a = a & ~((12'd1 << sz) - 12'd1);
                    end
                    push_model(a, l, sz, b, 4'(r));
                    send(a, l, sz, b, 4'(r));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    beat_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        beat_ready = 1'b1;
        wait_idle();

        // Reset mid-burst at beat 2 of a len-7 burst.
        begin
            int n;
            push_model(12'h400, 8'd7, 3'd2, 2'd1, 4'hA);
            send(12'h400, 8'd7, 3'd2, 2'd1, 4'hA);
            n = 0;
            @(negedge clk);
            while (beat_idx != 8'd2 && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("reach_beat2", 32'(beat_idx), 32'd2);
            #1;
            rst = 1'b1;
            @(negedge clk);
            sb.delete();
            check("midrst_beat_valid", 32'(beat_valid), 32'd0);
            check("midrst_busy", 32'(busy), 32'd0);
            check("midrst_beat_addr", 32'(beat_addr), 32'd0);
            check("midrst_beat_id", 32'(beat_id), 32'd0);
            check("midrst_beat_idx", 32'(beat_idx), 32'd0);
            check("midrst_beat_last", 32'(beat_last), 32'd0);
            check("midrst_beat_err", 32'(beat_err), 32'd0);
            check("midrst_ax_ready", 32'(ax_ready), 32'd0);
            sync();
            rst = 1'b0;
        end
        exp1(12'h500, 12'h500, 4'hB, 8'd0, 1'b0, 1'b0);
        exp1(12'h504, 12'h504, 4'hB, 8'd1, 1'b1, 1'b0);
        send(12'h500, 8'd1, 3'd2, 2'd1, 4'hB);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_burst_seq.md
# axi_burst_seq

Burst sequencer for the AXI slave-side address path. It accepts one AR/AW request per handshake and expands it into one address beat per transfer, len+1 beats in total, on a valid/ready beat interface. It computes each next beat address internally from the current beat address, burst, size and len. It sits between the slave's address channel and the memory/register access stage.

## Interface
- ADDR_WIDTH, 12: address width.
- DATA_WIDTH, 32: data bus width in bits; DATA_SIZE = log2(DATA_WIDTH) - 3.
- ID_WIDTH, 4: transaction ID width.
- ALIGN_ADDR, 1'b1: realign INCR beat addresses to size after the first beat.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- ax_valid  in  1  request valid.
- ax_ready  out  1  request ready.
- ax_addr  in  ADDR_WIDTH  start address.
- ax_len  in  8  beats minus 1.
- ax_size  in  3  log2 bytes per beat.
- ax_burst  in  2  burst type: 0 FIXED, 1 INCR, 2 WRAP, 3 RESERVED.
- ax_id  in  ID_WIDTH  transaction ID.
- beat_valid  out  1  beat valid.
- beat_ready  in  1  beat ready.
- beat_addr  out  ADDR_WIDTH  beat address.
- beat_id  out  ID_WIDTH  captured ID.
- beat_idx  out  8  beat index, 0..len.
- beat_last  out  1  high when beat_idx == len.
- beat_err  out  1  illegal request flag; constant for the whole burst.
- busy  out  1  burst in progress.

## Operation
- **States:**
  - IDLE: busy=0, beat_valid=0.
  - BURST: busy=1, beat_valid=1.
- **IDLE:** ax_ready=1. On ax_valid, capture addr/len/size/burst/id and go to BURST with beat_addr=ax_addr, beat_idx=0.
- **BURST:** a beat completes when beat_valid & beat_ready.
  - If the completing beat is not last: beat_idx+1, beat_addr=next address.
  - If it is last: return to IDLE, unless a new request is accepted in the same cycle (see back-to-back).
- **Back-to-back:** ax_ready = !busy | (beat_valid & beat_ready & beat_last). This path is combinational from beat_ready.
  - On a simultaneous last-beat completion and request accept, load the new burst directly and stay in BURST. No bubble.
- **Next address:** let nbytes = 1 << size. All sums are modulo 2^ADDR_WIDTH; there is no 4KB boundary check.
  - FIXED and RESERVED: next = addr.
  - INCR: next = addr + nbytes. If ALIGN_ADDR, clear bits [size-1:0] of next, limited to bits below DATA_SIZE.
  - WRAP: wrap_mask = zero-extended len[3:0] << size. next = (addr & ~wrap_mask) | ((addr + nbytes) & wrap_mask).
- **beat_err is set for the whole burst when any of these holds:**
  - burst == RESERVED;
  - size > DATA_SIZE;
  - WRAP with len not in {1, 3, 7, 15};
  - WRAP with addr not aligned to nbytes.
- Errored bursts still emit len+1 beats with addresses computed as above.

## Timing
- First beat_valid is one cycle after the ax_valid & ax_ready handshake.
- Throughput: one beat per cycle while beat_ready=1.
- Stall: while beat_valid & !beat_ready, all beat_* outputs hold stable.
- beat_last is combinational from beat_idx and the captured len.
- Reset values: busy=0, beat_valid=0, beat_addr=0, beat_id=0, beat_idx=0, beat_last=0, beat_err=0.
- ax_ready is 0 during the reset cycle and 1 in the first cycle after reset.
- Reset mid-burst: the burst is abandoned. No further beats; IDLE in the next cycle.
- len=0: single beat with beat_last=1 on beat 0.
- A burst of len+1 beats with beat_ready held high occupies exactly len+1 cycles of beat_valid.

## Test plan
- INCR, addr 0x100, len 3, size 2 -> beats 0x100, 0x104, 0x108, 0x10C; beat_last only on idx 3; beat_err=0.
- WRAP, addr 0x108, len 3, size 2 -> beats 0x108, 0x10C, 0x100, 0x104.
  - Same request with len 2 -> beat_err=1 on all 3 beats.
- INCR unaligned, addr 0x101, size 2, len 2, ALIGN_ADDR=1 -> beats 0x101, 0x104, 0x108.
  - With ALIGN_ADDR=0 -> beats 0x101, 0x105, 0x109.
- FIXED, addr 0x040, len 2 -> three beats at 0x040.
  - INCR, addr 0xFFC, size 2, len 1 -> beats 0xFFC, 0x000.
- Back-to-back: two INCR len 1 requests, beat_ready=1 -> 4 consecutive beat_valid cycles, no bubble; second request accepted on the first request's last beat.
  - Then a random beat_ready stall pattern -> beat_* outputs stable while stalled.
- Assert rst at beat 2 of a len-7 burst -> next cycle beat_valid=0, busy=0, all beat_* outputs 0.
  - Next request starts cleanly at beat_idx 0.
